// File: rtl/serial_quad_receiver.sv
// UART-style 4-bit serial receiver: start, 4 data LSB first, stop.
// Optional even-parity bit when PARITY_EN_EN is defined.
module serial_quad_receiver #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_in,
  output logic [3:0] data_out,
  output logic       data_valid,
  output logic       frame_error,
  output logic       busy,
  output logic       parity_error
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cfg
    $error("CLKS_PER_BIT must be 4 or more");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t state, state_n;

  logic          sync1, rx;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    idx, idx_n;
  logic [3:0]    shift, shift_n;
  logic [3:0]    out_n;
  logic          dv_n, fe_n;

`ifdef PARITY_EN_EN
  logic par_bad, par_bad_n;
  logic pe_n;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1       <= 1'b1;
      rx          <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      sync1       <= serial_in;
      rx          <= sync1;
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shift       <= shift_n;
      data_out    <= out_n;
      data_valid  <= dv_n;
      frame_error <= fe_n;
    end
  end

`ifdef PARITY_EN_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      par_bad      <= 1'b0;
      parity_error <= 1'b0;
    end else begin
      par_bad      <= par_bad_n;
      parity_error <= pe_n;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    out_n   = data_out;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
`ifdef PARITY_EN_EN
    par_bad_n = par_bad;
    pe_n      = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        cnt_n = '0;
`ifdef PARITY_EN_EN
        par_bad_n = 1'b0;
`endif
        if (!rx) state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n = '0;
          idx_n = '0;
          state_n = rx ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          shift_n[idx] = rx;
          if (idx == 2'd3) begin
`ifdef PARITY_EN_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 2'd1;
          end
        end
      end
`ifdef PARITY_EN_EN
      PARITY: begin
        if (cnt == FULL) begin
          cnt_n     = '0;
          par_bad_n = ^{shift, rx};
          state_n   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          if (rx) begin
            state_n = IDLE;
`ifdef PARITY_EN_EN
            if (par_bad) begin
              pe_n = 1'b1;
            end else begin
              out_n = shift;
              dv_n  = 1'b1;
            end
`else
            out_n = shift;
            dv_n  = 1'b1;
`endif
          end else begin
            fe_n    = 1'b1;
            state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // a held-low break must see high before a new start is armed
        cnt_n = '0;
        if (rx) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_quad_receiver.sv
// Scoreboard bench for serial_quad_receiver at CLKS_PER_BIT=4.
// Stimulus pushes expected pulses; a negedge monitor pops and checks.
module tb_serial_quad_receiver;

  localparam int C = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       serial_in = 1'b1;
  logic [3:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;
  logic       parity_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         kind;
    logic [3:0] data;
  } exp_t;

  exp_t q[$];
  logic [3:0] last_good = 4'h0;

  serial_quad_receiver #(.CLKS_PER_BIT(C)) dut (
    .clock        (clock),
    .reset        (reset),
    .serial_in    (serial_in),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .frame_error  (frame_error),
    .busy         (busy),
    .parity_error (parity_error)
  );

  always #5 clock = ~clock;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(logic b);
    @(posedge clock);
    #1 serial_in = b;
    repeat (C - 1) @(posedge clock);
  endtask

  // kind: 0 data_valid, 1 frame_error, 2 parity_error
  task automatic send_frame(logic [3:0] d, logic stop, logic bad_par);
    exp_t e;
    if (!stop) begin
      e.kind = 1;
      e.data = last_good;
    end else if (bad_par) begin
      e.kind = 2;
      e.data = last_good;
    end else begin
      e.kind = 0;
      e.data = d;
      last_good = d;
    end
    q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
`ifdef PARITY_EN_EN
    drive_bit(^d ^ bad_par);
`endif
    drive_bit(stop);
  endtask

  task automatic drain(string name);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    check(name, q.size(), 0);
    repeat (3) @(posedge clock);
  endtask

  task automatic check_quiet(string name);
    @(negedge clock);
    check({name, "_dout"}, data_out, 0);
    check({name, "_dv"}, data_valid, 0);
    check({name, "_fe"}, frame_error, 0);
    check({name, "_pe"}, parity_error, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    int   k;
    if (!reset && (data_valid || frame_error || parity_error)) begin
      check("one_pulse", data_valid + frame_error + parity_error, 1);
      k = data_valid ? 0 : (frame_error ? 1 : 2);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got kind %0d dout %0h expected none",
                 k, data_out);
      end else begin
        e = q.pop_front();
        check("pulse_kind", k, e.kind);
        check("pulse_dout", data_out, e.data);
        if (data_valid) check("busy_at_valid", busy, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check_quiet("reset");
    repeat (50) @(posedge clock);
    check_quiet("idle50");

    send_frame(4'hD, 1'b1, 1'b0);
    send_frame(4'h0, 1'b1, 1'b0);
    drain("b2b_drain");
    check("b2b_dout", data_out, 4'h0);

    send_frame(4'h9, 1'b1, 1'b0);
    drain("setup9_drain");

    @(posedge clock);
    #1 serial_in = 1'b0;
    @(posedge clock);
    #1 serial_in = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check("glitch_busy", busy, 0);
    check("glitch_dout", data_out, 4'h9);

    send_frame(4'h5, 1'b0, 1'b0);
    repeat (20) @(posedge clock);
    @(negedge clock);
    check("break_busy", busy, 1);
    check("break_q", q.size(), 0);
    check("break_dout", data_out, 4'h9);
    @(posedge clock);
    #1 serial_in = 1'b1;
    repeat (6) @(posedge clock);
    @(negedge clock);
    check("break_end_busy", busy, 0);
    send_frame(4'hA, 1'b1, 1'b0);
    drain("a_drain");
    check("a_dout", data_out, 4'hA);

    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    @(posedge clock);
    #1 serial_in = 1'b1;
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    check_quiet("midreset");
    #1 reset = 1'b0;
    last_good = 4'h0;
    repeat (40) @(posedge clock);
    check_quiet("postreset");
    send_frame(4'h3, 1'b1, 1'b0);
    drain("three_drain");
    check("three_dout", data_out, 4'h3);

`ifdef PARITY_EN_EN
    send_frame(4'h7, 1'b1, 1'b0);
    drain("par_ok_drain");
    check("par_ok_dout", data_out, 4'h7);
    send_frame(4'h7, 1'b1, 1'b1);
    drain("par_bad_drain");
    check("par_bad_dout", data_out, 4'h7);
    send_frame(4'h6, 1'b0, 1'b1);
    drain("par_fe_drain");
    @(posedge clock);
    #1 serial_in = 1'b1;
    repeat (6) @(posedge clock);
`endif

    repeat (20) @(posedge clock);
    check("final_q", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
